// File: rtl/bsg_manycore_pod_tag_reset_master.sv
// ============================================================================
// Module : bsg_manycore_pod_tag_reset_master
// Serialises pod reset commands into the bsg_tag bit stream (start, node id,
// data_not_reset, length, payload, idle gap), with an all-pods broadcast sweep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bsg_manycore_pod_tag_reset_master #(
  parameter int num_pods_x_p     = 2,
  parameter int num_pods_y_p     = 2,
  parameter int node_id_offset_p = 0,
  parameter int node_id_width_p  = 4,
  parameter int len_width_p      = 2,
  parameter int payload_width_p  = 1,
  parameter int gap_cycles_p     = 4,
  localparam int x_w = (num_pods_x_p > 1) ? $clog2(num_pods_x_p) : 1,
  localparam int y_w = (num_pods_y_p > 1) ? $clog2(num_pods_y_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [1:0]                 op_i,
  input  logic [x_w-1:0]             pod_x_i,
  input  logic [y_w-1:0]             pod_y_i,
  input  logic [payload_width_p-1:0] data_i,
  output logic                       tag_data_o,
  output logic                       done_o
);

  localparam int w01       = (node_id_width_p > len_width_p) ? node_id_width_p : len_width_p;
  localparam int w23       = (payload_width_p > gap_cycles_p) ? payload_width_p : gap_cycles_p;
  localparam int max_field = (w01 > w23) ? w01 : w23;
  localparam int cnt_w     = $clog2(max_field + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] NODE  = 3'd2;
  localparam logic [2:0] DNR   = 3'd3;
  localparam logic [2:0] LEN   = 3'd4;
  localparam logic [2:0] PAY   = 3'd5;
  localparam logic [2:0] GAP   = 3'd6;
  localparam logic [2:0] NOP   = 3'd7;

  localparam logic [1:0] OP_RESET = 2'd1;
  localparam logic [1:0] OP_BCAST = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  if (gap_cycles_p < 1) begin : g_bad_gap
    $error("gap_cycles_p must be at least 1");
  end
  if ((node_id_offset_p + num_pods_x_p * num_pods_y_p - 1) >= (1 << node_id_width_p)) begin : g_bad_node
    $error("pod node ids do not fit in node_id_width_p");
  end
  if (payload_width_p >= (1 << len_width_p)) begin : g_bad_len
    $error("payload_width_p does not fit in len_width_p");
  end

  logic [2:0]                 state;
  logic [cnt_w-1:0]           cnt;
  logic [1:0]                 op;
  logic [x_w-1:0]             x;
  logic [y_w-1:0]             y;
  logic [payload_width_p-1:0] data;

  logic [node_id_width_p-1:0] node_id, node_sh;
  logic [len_width_p-1:0]     len_val, len_sh;
  logic [payload_width_p-1:0] pay_val, pay_sh;
  logic                       last_pod, gap_end;

  // x/y double as the broadcast sweep position, so node id comes from one place
  assign node_id  = node_id_width_p'(node_id_offset_p)
                  + node_id_width_p'(y) * node_id_width_p'(num_pods_x_p)
                  + node_id_width_p'(x);
  assign len_val  = len_width_p'(payload_width_p);
  assign pay_val  = (op == OP_RESET) ? '1 : data;
  assign node_sh  = node_id >> cnt;
  assign len_sh   = len_val >> cnt;
  assign pay_sh   = pay_val >> cnt;
  assign last_pod = (x == x_w'(num_pods_x_p - 1)) && (y == y_w'(num_pods_y_p - 1));
  assign gap_end  = (state == GAP) && (cnt == cnt_w'(gap_cycles_p - 1));

  assign ready_o  = (state == IDLE) && !reset_i;
  assign done_o   = (gap_end && ((op != OP_BCAST) || last_pod)) || (state == NOP);

  always_comb begin
    tag_data_o = 1'b0;
    case (state)
      START:   tag_data_o = 1'b1;
      NODE:    tag_data_o = node_sh[0];
      DNR:     tag_data_o = (op != OP_RESET);
      LEN:     tag_data_o = len_sh[0];
      PAY:     tag_data_o = pay_sh[0];
      default: tag_data_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      x     <= '0;
      y     <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (v_i) begin
            op    <= op_i;
            data  <= data_i;
            cnt   <= '0;
            x     <= (op_i == OP_BCAST) ? '0 : pod_x_i;
            y     <= (op_i == OP_BCAST) ? '0 : pod_y_i;
            state <= (op_i == OP_RSVD) ? NOP : START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= NODE;
        end
        NODE: begin
          if (cnt == cnt_w'(node_id_width_p - 1)) begin
            cnt   <= '0;
            state <= DNR;
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        DNR: begin
          cnt   <= '0;
          state <= LEN;
        end
        LEN: begin
          if (cnt == cnt_w'(len_width_p - 1)) begin
            cnt   <= '0;
            state <= PAY;
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        PAY: begin
          if (cnt == cnt_w'(payload_width_p - 1)) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            cnt <= '0;
            if ((op == OP_BCAST) && !last_pod) begin
              // raster order: x fastest, then next row
              if (x == x_w'(num_pods_x_p - 1)) begin
                x <= '0;
                y <= y + y_w'(1);
              end else begin
                x <= x + x_w'(1);
              end
              state <= START;
            end else begin
              if (op == OP_BCAST) begin
                x <= '0;
                y <= '0;
              end
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_pod_tag_reset_master.sv
// ============================================================================
// Module : tb_bsg_manycore_pod_tag_reset_master
// Randomised and directed bench comparing the serial tag stream to a packet model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_manycore_pod_tag_reset_master;

  localparam int NX   = 2;
  localparam int NY   = 2;
  localparam int OFF  = 0;
  localparam int IDW  = 4;
  localparam int LENW = 2;
  localparam int PW   = 1;
  localparam int GAP  = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic          ready_o;
  logic [1:0]    op_i = '0;
  logic [0:0]    pod_x_i = '0;
  logic [0:0]    pod_y_i = '0;
  logic [PW-1:0] data_i = '0;
  logic          tag_data_o;
  logic          done_o;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  bsg_manycore_pod_tag_reset_master #(
    .num_pods_x_p(NX), .num_pods_y_p(NY), .node_id_offset_p(OFF),
    .node_id_width_p(IDW), .len_width_p(LENW), .payload_width_p(PW),
    .gap_cycles_p(GAP)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .op_i(op_i), .pod_x_i(pod_x_i), .pod_y_i(pod_y_i), .data_i(data_i),
    .tag_data_o(tag_data_o), .done_o(done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %0s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole command as the bit sequence seen on the line after acceptance
  function automatic void build_expected(input int op, input int px, input int py, input int d);
    int xs[$];
    int ys[$];
    exp_q.delete();
    if (op == 3) begin
      exp_q.push_back(1'b0);
      return;
    end
    if (op == 2) begin
      for (int j = 0; j < NY; j++)
        for (int i = 0; i < NX; i++) begin
          xs.push_back(i);
          ys.push_back(j);
        end
    end else begin
      xs.push_back(px);
      ys.push_back(py);
    end
    foreach (xs[k]) begin
      int id;
      id = (OFF + ys[k] * NX + xs[k]) % (1 << IDW);
      exp_q.push_back(1'b1);
      for (int b = 0; b < IDW; b++) exp_q.push_back(((id >> b) & 1) != 0);
      exp_q.push_back(op != 1);
      for (int b = 0; b < LENW; b++) exp_q.push_back(((PW >> b) & 1) != 0);
      for (int b = 0; b < PW; b++) exp_q.push_back((op == 1) ? 1'b1 : (((d >> b) & 1) != 0));
      for (int b = 0; b < GAP; b++) exp_q.push_back(1'b0);
    end
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready_o), 32'd1);
  endtask

  // Called at a negedge with ready_o high; returns at the negedge after done_o
  task automatic send(input int op, input int px, input int py, input int d, input bit keep_v);
    v_i     = 1'b1;
    op_i    = 2'(op);
    pod_x_i = 1'(px);
    pod_y_i = 1'(py);
    data_i  = PW'(d);
    build_expected(op, px, py, d);
    @(posedge clk);
    @(negedge clk);
    if (keep_v) begin
      op_i    = 2'($urandom_range(0, 3));
      pod_x_i = 1'($urandom);
      pod_y_i = 1'($urandom);
      data_i  = PW'($urandom);
    end else begin
      v_i = 1'b0;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("bit op%0d i%0d", op, i), 32'(tag_data_o), 32'(exp_q[i]));
      check($sformatf("done op%0d i%0d", op, i), 32'(done_o), 32'(i == exp_q.size() - 1));
      if (i != exp_q.size() - 1) begin
        check($sformatf("busy op%0d i%0d", op, i), 32'(ready_o), 32'd0);
      end
      @(negedge clk);
    end
    check($sformatf("ready_after op%0d", op), 32'(ready_o), 32'd1);
    check($sformatf("done_low op%0d", op), 32'(done_o), 32'd0);
  endtask

  initial begin
    int dones;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_tag", 32'(tag_data_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    check("ready_post_rst", 32'(ready_o), 32'd1);

    send(0, 1, 1, 1, 1'b0);
    send(1, 0, 0, 0, 1'b0);
    send(2, 0, 0, 0, 1'b0);
    send(3, 0, 0, 0, 1'b0);

    // v_i held through a command: second one is taken the cycle ready_o returns
    send(0, 0, 1, 1, 1'b1);
    send(0, 1, 0, 0, 1'b0);

    // reset in the middle of the payload bit
    wait_ready();
    v_i = 1'b1; op_i = 2'd0; pod_x_i = 1'b1; pod_y_i = 1'b0; data_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    repeat (8) @(negedge clk);
    check("pay_before_rst", 32'(tag_data_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check("tag_in_rst", 32'(tag_data_o), 32'd0);
    check("ready_in_rst", 32'(ready_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o) dones++;
      if (i == 0) check("ready_after_rst", 32'(ready_o), 32'd1);
    end
    check("no_done_after_rst", 32'(dones), 32'd0);

    for (int n = 0; n < 25; n++) begin
      wait_ready();
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, NX - 1)),
           int'($urandom_range(0, NY - 1)), int'($urandom_range(0, (1 << PW) - 1)),
           bit'($urandom_range(0, 1)));
    end
    v_i = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
